// File: rtl/lehmer_prng_if.sv
// Request/result bundle for the Lehmer PRNG coprocessor.
// Handshake: 4-phase; master raises start with operands valid, slave raises done
// with rand_val valid, master drops start, slave drops done on the next edge.
interface lehmer_prng_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] seed;
    logic             start;
    logic             cont;
    logic             done;
    logic [WIDTH-1:0] rand_val;

    modport master (
        output m, a, seed, start, cont,
        input  done, rand_val
    );

    modport slave (
        input  m, a, seed, start, cont,
        output done, rand_val
    );
endinterface

// File: rtl/lehmer_prng.sv
// Lehmer generator rand = (a * s) mod m; one multiply cycle, then 2*WIDTH restoring-division steps.
// Optional macro PRNG_ZERO_GUARD_EN replaces a zero seed by 1 so the sequence cannot stick at 0.
module lehmer_prng #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    lehmer_prng_if.slave       bus,
    output logic [1:0]         dbg_state
);
    localparam int CW = $clog2(2 * WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(2 * WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   m_lat;
    logic [WIDTH-1:0]   a_lat;
    logic [WIDTH-1:0]   s_lat;
    logic [WIDTH-1:0]   last;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   s_sel;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_next;
    logic [WIDTH-1:0]   result;

    always_comb begin
        s_sel = bus.cont ? last : bus.seed;
`ifdef PRNG_ZERO_GUARD_EN
        if (s_sel == '0) s_sel = WIDTH'(1);
`endif
    end

    // Remainder stays below m, so the shifted value fits in WIDTH+1 bits.
    always_comb begin
        rem_shift = {rem, prod[2*WIDTH-1]};
        if (rem_shift >= {1'b0, m_lat}) rem_next = rem_shift - {1'b0, m_lat};
        else                            rem_next = rem_shift;
        // The top bit can only survive when m is 0, which forces the result to 0 anyway.
        if (m_lat == '0 || rem_next[WIDTH]) result = '0;
        else                                result = rem_next[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            bus.done     <= 1'b0;
            bus.rand_val <= '0;
            last         <= '0;
            m_lat        <= '0;
            a_lat        <= '0;
            s_lat        <= '0;
            rem          <= '0;
            prod         <= '0;
            cnt          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        m_lat <= bus.m;
                        a_lat <= bus.a;
                        s_lat <= s_sel;
                        state <= MUL;
                    end
                end
                MUL: begin
                    prod  <= {{WIDTH{1'b0}}, a_lat} * {{WIDTH{1'b0}}, s_lat};
                    rem   <= '0;
                    cnt   <= '0;
                    state <= DIV;
                end
                DIV: begin
                    rem  <= rem_next[WIDTH-1:0];
                    prod <= {prod[2*WIDTH-2:0], 1'b0};
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        bus.rand_val <= result;
                        last         <= result;
                        bus.done     <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.start) begin
                        bus.done <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;
endmodule

// File: tb/tb_lehmer_prng.sv
// Self-checking bench for lehmer_prng: expected results queued at request time, popped at done.
module tb_lehmer_prng;
    localparam int W = 32;
    localparam logic [31:0] MINSTD_M = 32'd2147483647;
    localparam logic [31:0] MINSTD_A = 32'd16807;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    lehmer_prng_if #(.WIDTH(W)) bus ();

    lehmer_prng #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_model;
    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] mm, input logic [W-1:0] aa,
                                           input logic [W-1:0] ss);
        logic [63:0]  p;
        logic [W-1:0] s_e;
        s_e = ss;
`ifdef PRNG_ZERO_GUARD_EN
        if (s_e == '0) s_e = 32'd1;
`endif
        if (mm == '0) return '0;
        p = {32'b0, aa} * {32'b0, s_e};
        return 32'(p % {32'b0, mm});
    endfunction

    // driver: one full transaction, optional 1-cycle start pulse and mid-run operand pokes
    task automatic run_txn(input logic [W-1:0] mm, input logic [W-1:0] aa, input logic [W-1:0] ss,
                           input logic cc, input bit pulse, input bit poke,
                           input logic [W-1:0] exp);
        int edges;
        bit got;
        logic [W-1:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.m = mm; bus.a = aa; bus.seed = ss; bus.cont = cc; bus.start = 1'b1;
        edges = 0;
        got = 1'b0;
        while (edges < 200 && !got) begin
            @(posedge clk); #1;
            edges++;
            if (pulse && edges == 1) bus.start = 1'b0;
            if (poke && edges == 10) begin
                bus.seed = $urandom; bus.a = $urandom; bus.m = $urandom; bus.cont = ~cc;
            end
            if (bus.done) got = 1'b1;
        end
        if (got) check("latency", 32'(edges), 32'd66);
        else     check("done_timeout", 32'd0, 32'd1);
        e = exp_q.pop_front();
        check("rand", bus.rand_val, e);
        if (got) begin
            last_model = e;
            if (!pulse) begin
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk); #1;
                    check("done_hold", 32'(bus.done), 32'd1);
                end
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            check("done_drop", 32'(bus.done), 32'd0);
            check("rand_stable", bus.rand_val, e);
            repeat (2) @(posedge clk);
            #1;
            check("idle", 32'(dbg_state), 32'd0);
        end
        bus.start = 1'b0;
    endtask

    // reset while the reducer is about 30 steps in; no result may appear afterwards
    task automatic run_abort();
        bit seen;
        @(negedge clk);
        bus.m = MINSTD_M; bus.a = MINSTD_A; bus.seed = 32'd99991; bus.cont = 1'b0; bus.start = 1'b1;
        repeat (32) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_rand", bus.rand_val, 32'd0);
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1'b1;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        last_model = '0;
    endtask

    initial begin
        logic [W-1:0] mm, aa, ss, zexp;
        logic cc;
        n_checks = 0;
        n_pass = 0;
        last_model = '0;
        rst = 1'b0;
        bus.m = MINSTD_M; bus.a = MINSTD_A; bus.seed = 32'd5; bus.cont = 1'b0; bus.start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rand", bus.rand_val, 32'd0);
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_idle", 32'(dbg_state), 32'd0);

`ifdef PRNG_ZERO_GUARD_EN
        zexp = 32'd16807;
`else
        zexp = 32'd0;
`endif

        run_txn(MINSTD_M, MINSTD_A, 32'd1749629467, 1'b0, 1'b0, 1'b0, 32'd528873498);
        run_txn(MINSTD_M, MINSTD_A, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'd342065953);
        run_txn(MINSTD_M, MINSTD_A, 32'd528873498, 1'b0, 1'b0, 1'b0, 32'd342065953);
        run_txn(32'd7, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 32'd1);
        run_txn(32'd0, $urandom, $urandom, 1'b0, 1'b0, 1'b0, 32'd0);
        run_txn(MINSTD_M, MINSTD_A, 32'd12345, 1'b0, 1'b1, 1'b0, model(MINSTD_M, MINSTD_A, 32'd12345));
        run_txn(MINSTD_M, MINSTD_A, 32'd777, 1'b0, 1'b0, 1'b1, model(MINSTD_M, MINSTD_A, 32'd777));
        run_txn(32'd1000, 32'd48271, 32'hF000_0001, 1'b0, 1'b0, 1'b0, model(32'd1000, 32'd48271, 32'hF000_0001));
        run_abort();
        run_txn(MINSTD_M, MINSTD_A, 32'd4242, 1'b1, 1'b0, 1'b0, zexp);
        run_txn(MINSTD_M, MINSTD_A, 32'd0, 1'b0, 1'b0, 1'b0, zexp);

        for (int i = 0; i < 6; i++) begin
            mm = $urandom_range(32'hFFFF_FFFF, 1);
            aa = $urandom;
            ss = $urandom;
            cc = 1'($urandom_range(1, 0));
            run_txn(mm, aa, ss, cc, 1'b0, 1'b0, model(mm, aa, cc ? last_model : ss));
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/lehmer_prng.md
Name: lehmer_prng

Overview:
- Multiplicative linear congruential (Lehmer) pseudo-random number generator computing rand = (a * s) mod m, where s is the external seed or the previous result.
- Runs as a multi-cycle coprocessor: a 4-phase start/done handshake and a sequential shift-subtract modulo reducer.
- Used as the system random source; MINSTD (a=16807, m=2^31-1) is the reference configuration.

Parameters:
- WIDTH, 32, width of m, a, seed and rand. The product is 2*WIDTH bits; the reducer runs 2*WIDTH steps.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-low reset; 0 = reset, sampled on rising clk
- m  input  WIDTH  modulus
- a  input  WIDTH  multiplier
- seed  input  WIDTH  external seed
- start  input  1  request; level-held until done seen
- cont  input  1  1 = use previous result as seed, ignoring the seed port
- done  output  1  result valid, handshake acknowledge
- rand  output  WIDTH  last computed result

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, done=0, rand=0, internal last-result register=0. Reset mid-computation aborts it; no result is produced.
- States and transitions:
  - IDLE: done=0. On an edge with start=1, latch m, a, and s into working registers, then go to MUL. s = last-result if cont=1, else seed.
  - MUL: one cycle; product P = a_lat * s_lat, full 2*WIDTH bits, unsigned. Go to DIV with step count 0.
  - DIV: exactly 2*WIDTH cycles of restoring shift-subtract reduction of P by m_lat. Each step: remainder = (remainder<<1)|next P bit; subtract m_lat if remainder >= m_lat. The remainder register is WIDTH+1 bits. After the last step go to DONE.
  - DONE: on entry, rand and last-result both take the remainder; done=1. Stay while start=1. When start=0 at an edge, go to IDLE (done=0 the following cycle).
- Latency: counting the start-sampling edge as edge 1, done is 1 after edge 2*WIDTH+2 (66 for WIDTH=32).
- Inputs are ignored outside IDLE. Operand changes during a computation have no effect.
- If start drops before DONE, computation completes anyway; done is 1 for exactly one cycle, then the block returns to IDLE.
- start held high through DONE and back: no new computation until start has been seen 0 in DONE.
- rand is stable except at DONE entry and reset.
- m=0: result forced to 0; the full latency and handshake are unchanged.
- Operands are unsigned. seed >= m is legal; the result is always < m when m != 0.

Optional Feature:
- Macro PRNG_ZERO_GUARD_EN.
- Defined: if the selected s mod m would be 0 (s=0), s is replaced by 1 at latch time, so the generator never locks at 0.
- Undefined: s=0 yields rand=0, and cont chains then stay at 0.

Test Plan:
- Reset: rst=0 for 2 edges with start=1 -> done=0, rand=0. Release; IDLE is held until start is sampled.
- MINSTD: m=2147483647, a=16807, seed=1749629467, cont=0, start held until done -> rand=528873498. done rises exactly 66 edges after the start edge; start=0 -> done=0 next cycle.
- Chaining: then seed=528873498 via port (or cont=1) -> rand=342065953. Both paths must give the same value.
- Small modulus: m=7, a=3, seed=5 -> rand=1. m=0, any a and seed -> rand=0, done still asserted after 66 edges.
- Handshake edge cases:
  - start pulsed for 1 cycle -> done high for exactly 1 cycle, rand updated.
  - seed changed mid-computation -> result unaffected.
  - rst=0 at cycle 30 of DIV -> done=0, rand=0, no result.
- Zero seed: seed=0 -> rand=0 without PRNG_ZERO_GUARD_EN; rand=16807 (MINSTD a, m) with it.
